// File: rtl/axis_symbol_sampler.sv
// Symbol-rate sampler: picks one I/Q beat per symbol, queues it, frames it into packets.
// Generic FWFT FIFO first, then the sampler top.

// Generic first-word-fall-through FIFO, depth 2**AW.
// Latency: a push shows on pop_vld the next cycle; pop_dat is zero while empty.
// Backpressure: push is refused only when full with no simultaneous pop (push_acc=0).
module sampler_fifo #(
    parameter int DW = 8,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          push,
    input  logic [DW-1:0] push_dat,
    output logic          push_acc,
    input  logic          pop,
    output logic [DW-1:0] pop_dat,
    output logic          pop_vld,
    output logic [AW:0]   level
);
    logic [DW-1:0] mem [2**AW];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          pop_acc;

    assign full     = level[AW];
    assign pop_vld  = (level != '0);
    assign pop_acc  = pop & pop_vld;
    assign push_acc = push & (~full | pop_acc);
    assign pop_dat  = pop_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + AW'(1);
            if (pop_acc)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_acc, pop_acc})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc) mem[wr_ptr] <= push_dat;
    end
endmodule

// Selects one beat per symbol (internal phase counter or external strobe) into a packet FIFO.
// Latency: a selected beat is on o_tvalid the cycle after selection when the FIFO is empty.
// Backpressure: input never stalls; pushes into a full FIFO are dropped and counted.
module axis_symbol_sampler #(
    parameter int WIDTH   = 16,
    parameter int NCH     = 1,
    parameter int DECIM_W = 8,
    parameter int FIFO_AW = 5,
    parameter int PKT_W   = 16
) (
    input  logic                    ce_clk,
    input  logic                    ce_rst,
    input  logic                    clear,
    input  logic                    cfg_mode,
    input  logic [DECIM_W-1:0]      cfg_decim,
    input  logic [DECIM_W-1:0]      cfg_phase,
    input  logic [PKT_W-1:0]        cfg_pkt_len,
    input  logic                    sync_stb,
    input  logic [NCH*2*WIDTH-1:0]  i_tdata,
    input  logic                    i_tvalid,
    output logic                    i_tready,
    input  logic                    i_tlast,
    output logic [NCH*2*WIDTH-1:0]  o_tdata,
    output logic                    o_tvalid,
    input  logic                    o_tready,
    output logic                    o_tlast,
    output logic [15:0]             overflow_cnt,
    output logic [FIFO_AW:0]        fifo_level
);
    localparam int DW = NCH*2*WIDTH;

    logic [DECIM_W-1:0] d_eff;
    logic [DECIM_W-1:0] d_max;
    logic [DECIM_W-1:0] p_eff;
    logic [DECIM_W-1:0] cnt;
    logic [PKT_W-1:0]   pkt_cnt;
    logic [PKT_W-1:0]   pkt_last_idx;
    logic               pend;
    logic               sticky;
    logic               accept;
    logic               sel;
    logic               push;
    logic               push_acc;
    logic               tlast_bit;

    assign i_tready = ce_rst;
    assign accept   = i_tvalid & i_tready;

    assign d_eff = (cfg_decim == '0) ? DECIM_W'(1) : cfg_decim;
    assign d_max = d_eff - DECIM_W'(1);
    assign p_eff = (cfg_phase > d_max) ? d_max : cfg_phase;

    assign sel  = accept & (cfg_mode ? (sync_stb | pend) : (cnt == p_eff));
    assign push = sel & ~clear;

    // Fixed-length framing counts pushes; length 0 forwards the input framing instead.
    assign pkt_last_idx = cfg_pkt_len - PKT_W'(1);
    assign tlast_bit    = (cfg_pkt_len == '0) ? (sticky | i_tlast) : (pkt_cnt == pkt_last_idx);

    always_ff @(posedge ce_clk) begin
        if (!ce_rst) begin
            cnt          <= '0;
            pkt_cnt      <= '0;
            pend         <= 1'b0;
            sticky       <= 1'b0;
            overflow_cnt <= '0;
        end else if (clear) begin
            cnt     <= '0;
            pkt_cnt <= '0;
            pend    <= 1'b0;
            sticky  <= 1'b0;
        end else begin
            // A cnt left beyond a shrunk decimation wraps on the next accept.
            if (cfg_mode)    cnt <= '0;
            else if (accept) cnt <= (cnt >= d_max) ? '0 : cnt + DECIM_W'(1);

            if (!cfg_mode)     pend <= 1'b0;
            else if (accept)   pend <= 1'b0;
            else if (sync_stb) pend <= 1'b1;

            if (push_acc)                sticky <= 1'b0;
            else if (accept && i_tlast)  sticky <= 1'b1;

            if (push_acc) begin
                if (cfg_pkt_len == '0 || pkt_cnt >= pkt_last_idx) pkt_cnt <= '0;
                else                                               pkt_cnt <= pkt_cnt + PKT_W'(1);
            end

            if (push && !push_acc && overflow_cnt != 16'hFFFF)
                overflow_cnt <= overflow_cnt + 16'd1;
        end
    end

    sampler_fifo #(
        .DW (DW + 1),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk      (ce_clk),
        .rst_n    (ce_rst),
        .clr      (clear),
        .push     (push),
        .push_dat ({tlast_bit, i_tdata}),
        .push_acc (push_acc),
        .pop      (o_tready),
        .pop_dat  ({o_tlast, o_tdata}),
        .pop_vld  (o_tvalid),
        .level    (fifo_level)
    );
endmodule

// File: tb/tb_axis_symbol_sampler.sv
// Directed scoreboard bench for axis_symbol_sampler: stimulus queues expected symbols, a monitor pops and compares.
module tb_axis_symbol_sampler;
    logic        ce_clk = 1'b0;
    logic        ce_rst;
    logic        clear;
    logic        cfg_mode;
    logic [7:0]  cfg_decim;
    logic [7:0]  cfg_phase;
    logic [15:0] cfg_pkt_len;
    logic        sync_stb;
    logic [31:0] i_tdata;
    logic        i_tvalid;
    logic        i_tready;
    logic        i_tlast;
    logic [31:0] o_tdata;
    logic        o_tvalid;
    logic        o_tready;
    logic        o_tlast;
    logic [15:0] overflow_cnt;
    logic [5:0]  fifo_level;

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];

    axis_symbol_sampler #(
        .WIDTH(16), .NCH(1), .DECIM_W(8), .FIFO_AW(5), .PKT_W(16)
    ) dut (
        .ce_clk(ce_clk), .ce_rst(ce_rst), .clear(clear), .cfg_mode(cfg_mode),
        .cfg_decim(cfg_decim), .cfg_phase(cfg_phase), .cfg_pkt_len(cfg_pkt_len),
        .sync_stb(sync_stb), .i_tdata(i_tdata), .i_tvalid(i_tvalid),
        .i_tready(i_tready), .i_tlast(i_tlast), .o_tdata(o_tdata),
        .o_tvalid(o_tvalid), .o_tready(o_tready), .o_tlast(o_tlast),
        .overflow_cnt(overflow_cnt), .fifo_level(fifo_level)
    );

    always #5 ce_clk = ~ce_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every handshake consumes one expected symbol.
    initial begin
        forever begin
            logic [32:0] e;
            @(negedge ce_clk);
            if (o_tvalid === 1'b1 && o_tready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got %h expected none", {o_tlast, o_tdata});
                end else begin
                    e = exp_q.pop_front();
                    if ({o_tlast, o_tdata} !== e) begin
                        errors++;
                        $display("FAIL out_symbol: got %h expected %h", {o_tlast, o_tdata}, e);
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge ce_clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic last, input logic stb);
        i_tvalid = 1'b1;
        i_tdata  = d;
        i_tlast  = last;
        sync_stb = stb;
        step();
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
        sync_stb = 1'b0;
    endtask

    task automatic idle_stb();
        sync_stb = 1'b1;
        step();
        sync_stb = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic cfg(input logic mode, input logic [7:0] decim, input logic [7:0] phase,
                       input logic [15:0] plen);
        cfg_mode    = mode;
        cfg_decim   = decim;
        cfg_phase   = phase;
        cfg_pkt_len = plen;
    endtask

    task automatic expect_sym(input logic last, input logic [31:0] d);
        exp_q.push_back({last, d});
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || o_tvalid) && n < 1000) begin
            step();
            n++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        ce_rst = 1'b0; clear = 1'b0; sync_stb = 1'b0;
        i_tdata = '0; i_tvalid = 1'b0; i_tlast = 1'b0; o_tready = 1'b1;
        cfg(1'b0, 8'd1, 8'd0, 16'd0);
        repeat (3) step();
        chk("rst_i_tready", 32'(i_tready), 32'd0);
        chk("rst_o_tvalid", 32'(o_tvalid), 32'd0);
        chk("rst_o_tlast", 32'(o_tlast), 32'd0);
        chk("rst_o_tdata", o_tdata, 32'd0);
        chk("rst_fifo_level", 32'(fifo_level), 32'd0);
        chk("rst_overflow", 32'(overflow_cnt), 32'd0);
        ce_rst = 1'b1;
        step();
        chk("run_i_tready", 32'(i_tready), 32'd1);

        // Mode 0, D=4, P=1: beats 1,5,9,13
        cfg(1'b0, 8'd4, 8'd1, 16'd0);
        expect_sym(0, 1); expect_sym(0, 5); expect_sym(0, 9); expect_sym(0, 13);
        send(32'd0, 0, 0);
        chk("t1_no_valid_before_sel", 32'(o_tvalid), 32'd0);
        send(32'd1, 0, 0);
        chk("t1_first_valid_latency", 32'(o_tvalid), 32'd1);
        for (int i = 2; i < 16; i++) send(32'(i), 0, 0);
        drain("t1_drain");

        // Phase clamp: D=16, phase 20 -> 15
        pulse_clear();
        cfg(1'b0, 8'd16, 8'd20, 16'd0);
        expect_sym(0, 15); expect_sym(0, 31); expect_sym(0, 47);
        for (int i = 0; i < 48; i++) send(32'(i), 0, 0);
        drain("t2_drain");

        // External strobe mode: pending strobe, collapse, same-cycle strobe
        pulse_clear();
        cfg(1'b1, 8'd4, 8'd0, 16'd0);
        expect_sym(0, 32'hAAAA5555);
        expect_sym(0, 32'h12345678);
        expect_sym(0, 32'h00000077);
        idle_stb();
        send(32'hAAAA5555, 0, 0);
        send(32'h00001111, 0, 0);
        send(32'h00002222, 0, 0);
        idle_stb();
        idle_stb();
        send(32'h12345678, 0, 0);
        send(32'h0BAD0BAD, 0, 0);
        send(32'h00000077, 0, 1);
        send(32'h00000088, 0, 0);
        drain("t3_drain");

        // Fixed packet length 3, D=2: tlast on symbols 3,6,9
        pulse_clear();
        cfg(1'b0, 8'd2, 8'd0, 16'd3);
        for (int k = 0; k < 9; k++) expect_sym(k % 3 == 2, 32'(2 * k));
        for (int i = 0; i < 18; i++) send(32'(i), 0, 0);
        drain("t4_drain");

        // Sticky tlast: input tlast on unselected beat 5 lands on beat 8
        pulse_clear();
        cfg(1'b0, 8'd4, 8'd0, 16'd0);
        expect_sym(0, 0); expect_sym(0, 4); expect_sym(1, 8);
        for (int i = 0; i < 12; i++) send(32'(i), i == 5, 0);
        drain("t4b_drain");

        // Overflow: 40 symbols into a stalled 32-deep FIFO
        pulse_clear();
        cfg(1'b0, 8'd1, 8'd0, 16'd0);
        o_tready = 1'b0;
        for (int i = 0; i < 32; i++) expect_sym(0, 32'(100 + i));
        for (int i = 0; i < 40; i++) send(32'(100 + i), 0, 0);
        chk("t5_level_full", 32'(fifo_level), 32'd32);
        chk("t5_overflow", 32'(overflow_cnt), 32'd8);
        chk("t5_head_data", o_tdata, 32'd100);
        step(); step();
        chk("t5_head_stable", o_tdata, 32'd100);
        chk("t5_valid_stable", 32'(o_tvalid), 32'd1);
        // Push and pop together while full: accepted, no drop
        expect_sym(0, 32'd140);
        o_tready = 1'b1;
        send(32'd140, 0, 0);
        chk("t5_level_push_pop_full", 32'(fifo_level), 32'd32);
        chk("t5_overflow_no_drop", 32'(overflow_cnt), 32'd8);
        drain("t5_drain");

        // Clear mid-stream with 10 queued
        o_tready = 1'b0;
        for (int i = 0; i < 10; i++) send(32'(300 + i), 0, 0);
        chk("t6_level_before_clear", 32'(fifo_level), 32'd10);
        pulse_clear();
        chk("t6_valid_after_clear", 32'(o_tvalid), 32'd0);
        chk("t6_level_after_clear", 32'(fifo_level), 32'd0);
        chk("t6_overflow_kept", 32'(overflow_cnt), 32'd8);
        cfg(1'b0, 8'd4, 8'd2, 16'd0);
        o_tready = 1'b1;
        expect_sym(0, 32'd202); expect_sym(0, 32'd206);
        for (int i = 0; i < 8; i++) send(32'(200 + i), 0, 0);
        drain("t6_drain");

        // Reset mid-stream with 10 queued
        cfg(1'b0, 8'd1, 8'd0, 16'd0);
        o_tready = 1'b0;
        for (int i = 0; i < 10; i++) send(32'(500 + i), 0, 0);
        chk("t7_level_before_rst", 32'(fifo_level), 32'd10);
        ce_rst = 1'b0;
        step();
        chk("t7_i_tready_in_rst", 32'(i_tready), 32'd0);
        chk("t7_valid_after_rst", 32'(o_tvalid), 32'd0);
        chk("t7_level_after_rst", 32'(fifo_level), 32'd0);
        chk("t7_overflow_zeroed", 32'(overflow_cnt), 32'd0);
        ce_rst = 1'b1;
        step();
        cfg(1'b0, 8'd4, 8'd2, 16'd0);
        o_tready = 1'b1;
        expect_sym(0, 32'd402);
        for (int i = 0; i < 4; i++) send(32'(400 + i), 0, 0);
        drain("t7_drain");

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
